// File: rtl/trivium_stream_core_pkg.sv
// trivium_pkg: shared types and constants for the Trivium stream core.
//   core_state_e   : FSM state encoding used by trivium_stream_core.
//   STATE_LEN      : Trivium state length (bits s1..s288).
//   INIT_ROUNDS    : warm-up rounds run after every key/IV load.
//   TAP_*          : 1-based Trivium tap positions (s<n> lives at bit n-1).
//   load_state()   : builds the initial 288-bit state from key and IV.
package trivium_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_RUN,
        S_EXHAUSTED
    } core_state_e;

    localparam int unsigned STATE_LEN   = 288;
    localparam int unsigned INIT_ROUNDS = 1152;
    localparam int unsigned KEY_LEN     = 80;
    localparam int unsigned IV_LEN      = 80;

    localparam int unsigned TAP_66  = 66;
    localparam int unsigned TAP_93  = 93;
    localparam int unsigned TAP_91  = 91;
    localparam int unsigned TAP_92  = 92;
    localparam int unsigned TAP_171 = 171;
    localparam int unsigned TAP_162 = 162;
    localparam int unsigned TAP_177 = 177;
    localparam int unsigned TAP_175 = 175;
    localparam int unsigned TAP_176 = 176;
    localparam int unsigned TAP_264 = 264;
    localparam int unsigned TAP_243 = 243;
    localparam int unsigned TAP_288 = 288;
    localparam int unsigned TAP_286 = 286;
    localparam int unsigned TAP_287 = 287;
    localparam int unsigned TAP_69  = 69;

    // s1..s80 = key, s81..s93 = 0, s94..s173 = IV, s174..s285 = 0, s286..s288 = 1
    function automatic logic [STATE_LEN-1:0] load_state(
        input logic [KEY_LEN-1:0] key,
        input logic [IV_LEN-1:0]  iv
    );
        return {3'b111, 112'b0, iv, 13'b0, key};
    endfunction

endpackage

// File: rtl/trivium_stream_core_if.sv
// trivium_stream_core_if: key/IV load, data in/out handshakes and status
// flags of the Trivium stream core.
//   slave  : core side (takes key/IV/load/data, drives data/status outputs).
//   master : driver side (upstream FIFO, downstream FIFO and control).
// W must match the W of the core the interface is connected to.
interface trivium_stream_core_if #(
    parameter int unsigned W = 8
);
    logic [79:0]  key_i;
    logic [79:0]  iv_i;
    logic         load_i;
    logic [W-1:0] data_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [W-1:0] out_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         ready_o;
    logic         exhausted_o;
    logic         err_o;

    modport slave (
        input  key_i, iv_i, load_i, data_i, data_valid_i, out_ready_i,
        output data_ready_o, out_o, out_valid_o, ready_o, exhausted_o, err_o
    );

    modport master (
        output key_i, iv_i, load_i, data_i, data_valid_i, out_ready_i,
        input  data_ready_o, out_o, out_valid_o, ready_o, exhausted_o, err_o
    );
endinterface

// File: rtl/trivium_stream_core_rounds.sv
// trivium_rounds: purely combinational W-round Trivium step.
//   state_i : current 288-bit state (s<n> at bit n-1).
//   state_o : state after W rounds.
//   z_o     : keystream bits of those rounds, bit 0 = earliest.
module trivium_rounds
    import trivium_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [STATE_LEN-1:0] state_i,
    output logic [STATE_LEN-1:0] state_o,
    output logic [W-1:0]         z_o
);

    logic [STATE_LEN-1:0] st;
    logic                 t1, t2, t3;

    always_comb begin
        st  = state_i;
        z_o = '0;
        t1  = 1'b0;
        t2  = 1'b0;
        t3  = 1'b0;
        for (int unsigned r = 0; r < W; r++) begin
            t1 = st[TAP_66-1]  ^ st[TAP_93-1];
            t2 = st[TAP_162-1] ^ st[TAP_177-1];
            t3 = st[TAP_243-1] ^ st[TAP_288-1];
            z_o[r] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (st[TAP_91-1]  & st[TAP_92-1])  ^ st[TAP_171-1];
            t2 = t2 ^ (st[TAP_175-1] & st[TAP_176-1]) ^ st[TAP_264-1];
            t3 = t3 ^ (st[TAP_286-1] & st[TAP_287-1]) ^ st[TAP_69-1];
            // each register shifts up by one; the feedback bit enters at its lowest position
            st = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
        end
        state_o = st;
    end

endmodule

// File: rtl/trivium_stream_core.sv
// trivium_stream_core: W-bit-parallel Trivium cipher core.
//   clk, rst : clock, asynchronous active-low reset.
//   bus      : trivium_stream_core_if slave port
//              key_i/iv_i/load_i  - key/IV capture and restart,
//              data_i/data_valid_i/data_ready_o - input beats,
//              out_o/out_valid_o/out_ready_i    - data_i XOR keystream,
//              ready_o (RUN), exhausted_o (EXHAUSTED), err_o (sticky misuse).
// Parameters: W keystream bits per beat (1..64, divides 1152),
//             MAX_WORDS beats per key/IV before a reload is required.
module trivium_stream_core
    import trivium_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_WORDS = 2**20
) (
    input logic                clk,
    input logic                rst,
    trivium_stream_core_if.slave bus
);

    localparam int unsigned INIT_CYCLES = INIT_ROUNDS / W;
    localparam int unsigned RCW         = $clog2(INIT_CYCLES);
    localparam int unsigned WCW         = $clog2(MAX_WORDS + 1);
    localparam logic [RCW-1:0] RND_LAST  = RCW'(INIT_CYCLES - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(MAX_WORDS - 1);

    core_state_e          state_q, state_d;
    logic [STATE_LEN-1:0] s_q, s_d, s_next;
    logic [W-1:0]         z;
    logic [W-1:0]         out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ready_q, ready_d;
    logic                 exhausted_q, exhausted_d;
    logic                 err_q, err_d;
    logic [RCW-1:0]       rnd_q, rnd_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 data_ready;
    logic                 accept;

    trivium_rounds #(.W(W)) u_rounds (
        .state_i (s_q),
        .state_o (s_next),
        .z_o     (z)
    );

    assign data_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready_i);
    assign accept     = data_ready && bus.data_valid_i;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        rnd_d       = rnd_q;
        wcnt_d      = wcnt_q;

        if (bus.data_valid_i && (state_q != S_RUN)) begin
            err_d = 1'b1;
        end

        if (accept) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // The key/IV state is written at the load_i edge itself, so LOAD
        // only spends its cycle before INIT and no key/IV copy is kept.
        if (bus.load_i) begin
            state_d     = S_LOAD;
            s_d         = load_state(bus.key_i, bus.iv_i);
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            rnd_d       = '0;
            wcnt_d      = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: state_d = S_INIT;
                S_INIT: begin
                    s_d = s_next;
                    if (rnd_q == RND_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        rnd_d = rnd_q + RCW'(1);
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        s_d    = s_next;
                        out_d  = bus.data_i ^ z;
                        wcnt_d = wcnt_q + WCW'(1);
                        if (wcnt_q == WORD_LAST) begin
                            state_d = S_EXHAUSTED;
                        end
                    end
                end
                S_EXHAUSTED: ;
                default: state_d = S_IDLE;
            endcase
        end

        ready_d     = (state_d == S_RUN);
        exhausted_d = (state_d == S_EXHAUSTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            exhausted_q <= 1'b0;
            err_q       <= 1'b0;
            rnd_q       <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
            exhausted_q <= exhausted_d;
            err_q       <= err_d;
            rnd_q       <= rnd_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign bus.data_ready_o = data_ready;
    assign bus.out_o        = out_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.ready_o      = ready_q;
    assign bus.exhausted_o  = exhausted_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_trivium_stream_core.sv
// Self-checking bench for trivium_stream_core.
// Instances: 0 = W1, 1 = W8, 2 = W64, 3 = W8 with MAX_WORDS=4.
// Keystream expectations come from a bit-serial Trivium reference model.
module tb_trivium_stream_core;

    localparam logic [79:0] KEY1 = 80'h0F1E_2D3C_4B5A_6978_8796;
    localparam logic [79:0] IV1  = 80'hA5C3_0011_2233_4455_6677;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key_r, iv_r;
    logic        ld   [4];
    logic        vin  [4];
    logic        ordy [4];
    logic [63:0] din  [4];
    logic [63:0] dout [4];
    logic        ov [4], dr [4], rd [4], ex [4], er [4];

    int n_tests = 0;
    int n_fail  = 0;
    bit ks [2][512];
    bit ms [1:288];

    always #5 clk = ~clk;

    trivium_stream_core_if #(.W(1))  if1 ();
    trivium_stream_core_if #(.W(8))  if8 ();
    trivium_stream_core_if #(.W(64)) if64 ();
    trivium_stream_core_if #(.W(8))  ifm ();

    trivium_stream_core #(.W(1))  d1  (.clk(clk), .rst(rst), .bus(if1.slave));
    trivium_stream_core #(.W(8))  d8  (.clk(clk), .rst(rst), .bus(if8.slave));
    trivium_stream_core #(.W(64)) d64 (.clk(clk), .rst(rst), .bus(if64.slave));
    trivium_stream_core #(.W(8), .MAX_WORDS(4)) dm (.clk(clk), .rst(rst), .bus(ifm.slave));

    assign if1.key_i  = key_r; assign if1.iv_i  = iv_r; assign if1.load_i  = ld[0];
    assign if8.key_i  = key_r; assign if8.iv_i  = iv_r; assign if8.load_i  = ld[1];
    assign if64.key_i = key_r; assign if64.iv_i = iv_r; assign if64.load_i = ld[2];
    assign ifm.key_i  = key_r; assign ifm.iv_i  = iv_r; assign ifm.load_i  = ld[3];
    assign if1.data_i  = din[0][0:0]; assign if1.data_valid_i  = vin[0]; assign if1.out_ready_i  = ordy[0];
    assign if8.data_i  = din[1][7:0]; assign if8.data_valid_i  = vin[1]; assign if8.out_ready_i  = ordy[1];
    assign if64.data_i = din[2];      assign if64.data_valid_i = vin[2]; assign if64.out_ready_i = ordy[2];
    assign ifm.data_i  = din[3][7:0]; assign ifm.data_valid_i  = vin[3]; assign ifm.out_ready_i  = ordy[3];

    always_comb begin
        dout[0] = 64'(if1.out_o);  ov[0] = if1.out_valid_o;  dr[0] = if1.data_ready_o;
        rd[0] = if1.ready_o;  ex[0] = if1.exhausted_o;  er[0] = if1.err_o;
        dout[1] = 64'(if8.out_o);  ov[1] = if8.out_valid_o;  dr[1] = if8.data_ready_o;
        rd[1] = if8.ready_o;  ex[1] = if8.exhausted_o;  er[1] = if8.err_o;
        dout[2] = if64.out_o;      ov[2] = if64.out_valid_o; dr[2] = if64.data_ready_o;
        rd[2] = if64.ready_o; ex[2] = if64.exhausted_o; er[2] = if64.err_o;
        dout[3] = 64'(ifm.out_o);  ov[3] = ifm.out_valid_o;  dr[3] = ifm.data_ready_o;
        rd[3] = ifm.ready_o;  ex[3] = ifm.exhausted_o;  er[3] = ifm.err_o;
    end

    function automatic int unsigned wid(input int i);
        case (i)
            0: return 1;
            2: return 64;
            default: return 8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one Trivium round on the 1-based state ms.
    task automatic m_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
    endtask

    task automatic m_gen(input logic [79:0] k, input logic [79:0] v, input int which);
        bit z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) m_round(z);
        for (int p = 0; p < 512; p++) begin
            m_round(z);
            ks[which][p] = z;
        end
    endtask

    function automatic logic [63:0] expw(input int k, input int p, input int unsigned w,
                                         input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < int'(w); j++) r[j] = d[j] ^ ks[k][p + j];
        return r;
    endfunction

    task automatic wait_ready(input int i, output int cnt);
        cnt = 0;
        while (!rd[i] && cnt < 3000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_load(input int i);
        ld[i] = 1'b1;
        tick();
        ld[i] = 1'b0;
    endtask

    // Continuous valid, downstream always ready, starting at beat b0.
    task automatic stream(input int i, input int k, input int b0, input int n, input string tag);
        int unsigned w;
        logic [63:0] d;
        w = wid(i);
        for (int b = b0; b < b0 + n; b++) begin
            d = {$urandom, $urandom};
            din[i] = d; vin[i] = 1'b1; ordy[i] = 1'b1;
            tick();
            chk({tag, "_out"}, dout[i], expw(k, b * int'(w), w, d));
            chk({tag, "_ov"}, 64'(ov[i]), 64'd1);
        end
        vin[i] = 1'b0;
    endtask

    initial begin
        int cnt, c0, c2, nacc, cyc;
        logic r, eov, edr;
        logic [63:0] d, ew, last;

        rst = 1'b0; key_r = '0; iv_r = '0;
        for (int i = 0; i < 4; i++) begin
            ld[i] = 1'b0; vin[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0;
        end
        m_gen(80'h0, 80'h0, 0);
        m_gen(KEY1, IV1, 1);

        // reset values
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk("rst_dr", 64'(dr[i]), 0); chk("rst_ov", 64'(ov[i]), 0);
            chk("rst_rd", 64'(rd[i]), 0); chk("rst_ex", 64'(ex[i]), 0);
            chk("rst_er", 64'(er[i]), 0); chk("rst_out", dout[i], 0);
        end
        rst = 1'b1;
        tick();

        // data_valid in IDLE is a misuse; load clears it
        vin[1] = 1'b1;
        tick();
        vin[1] = 1'b0;
        chk("idle_err", 64'(er[1]), 1);
        chk("idle_dr", 64'(dr[1]), 0);

        // W=8, zero key/IV: init latency and 64 keystream bytes
        do_load(1);
        chk("load_clr_err", 64'(er[1]), 0);
        wait_ready(1, cnt);
        chk("lat_w8", cnt, 145);
        for (int b = 0; b < 64; b++) begin
            din[1] = '0; vin[1] = 1'b1; ordy[1] = 1'b1;
            tick();
            chk("ks0_w8", dout[1], expw(0, b * 8, 8, 64'h0));
        end
        vin[1] = 1'b0;

        // W=8, KEY1/IV1 with 50% random downstream stalls
        key_r = KEY1; iv_r = IV1;
        do_load(1);
        wait_ready(1, cnt);
        chk("lat_w8b", cnt, 145);
        nacc = 0; cyc = 0; eov = 1'b0; ew = '0; last = '0;
        while (nacc < 64 && cyc < 1000) begin
            r = 1'($urandom_range(0, 1));
            d = 64'($urandom_range(0, 255));
            ordy[1] = r; vin[1] = 1'b1; din[1] = d;
            #1;
            edr = !eov || r;
            chk("stall_dr", 64'(dr[1]), 64'(edr));
            if (edr) ew = expw(1, nacc * 8, 8, d);
            tick();
            if (edr) begin
                chk("stall_out", dout[1], ew);
                last = ew; nacc++; eov = 1'b1;
            end else begin
                chk("stall_hold", dout[1], last);
            end
            chk("stall_ov", 64'(ov[1]), 64'(eov));
            cyc++;
        end
        vin[1] = 1'b0; ordy[1] = 1'b1;
        chk("stall_beats", nacc, 64);

        // W=1 and W=64 on the same key/IV: latency and 512 bits each
        ld[0] = 1'b1; ld[2] = 1'b1;
        tick();
        ld[0] = 1'b0; ld[2] = 1'b0;
        c0 = -1; c2 = -1; cnt = 0;
        while ((c0 < 0 || c2 < 0) && cnt < 3000) begin
            tick();
            cnt++;
            if (rd[0] && c0 < 0) c0 = cnt;
            if (rd[2] && c2 < 0) c2 = cnt;
        end
        chk("lat_w1", c0, 1153);
        chk("lat_w64", c2, 19);
        stream(2, 1, 0, 8, "ks1_w64");
        stream(0, 1, 0, 512, "ks1_w1");

        // MAX_WORDS = 4: exhaustion, drain, misuse, reload
        key_r = '0; iv_r = '0;
        do_load(3);
        wait_ready(3, cnt);
        chk("lat_m", cnt, 145);
        stream(3, 0, 0, 3, "max");
        chk("max3_ex", 64'(ex[3]), 0);
        stream(3, 0, 3, 1, "max4");
        chk("max4_ex", 64'(ex[3]), 1);
        chk("max4_dr", 64'(dr[3]), 0);
        chk("max4_rd", 64'(rd[3]), 0);
        vin[3] = 1'b1;
        tick();
        vin[3] = 1'b0;
        chk("max5_err", 64'(er[3]), 1);
        chk("max5_drain", 64'(ov[3]), 0);
        do_load(3);
        chk("reload_ex", 64'(ex[3]), 0);
        chk("reload_err", 64'(er[3]), 0);

        // load in the middle of INIT restarts the full warm-up
        repeat (50) tick();
        do_load(3);
        wait_ready(3, cnt);
        chk("lat_midinit", cnt, 145);
        stream(3, 0, 0, 2, "pre_reload");

        // load together with an accept: accept dropped, keystream restarts
        din[3] = 64'h5A; vin[3] = 1'b1; ld[3] = 1'b1;
        tick();
        ld[3] = 1'b0; vin[3] = 1'b0;
        chk("load_acc_ov", 64'(ov[3]), 0);
        wait_ready(3, cnt);
        chk("lat_relaod", cnt, 145);
        stream(3, 0, 0, 1, "restart");

        // asynchronous reset during RUN
        din[1] = 64'h33; vin[1] = 1'b1;
        tick();
        vin[1] = 1'b0;
        chk("pre_rst_ov", 64'(ov[1]), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ov", 64'(ov[1]), 0); chk("arst_rd", 64'(rd[1]), 0);
        chk("arst_out", dout[1], 0);   chk("arst_dr", 64'(dr[1]), 0);
        chk("arst_er", 64'(er[1]), 0); chk("arst_ex", 64'(ex[1]), 0);
        rst = 1'b1;
        vin[1] = 1'b1;
        tick();
        vin[1] = 1'b0;
        chk("post_rst_err", 64'(er[1]), 1);
        chk("post_rst_rd", 64'(rd[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trivium_stream_core.md
# trivium_stream_core

Parametrised Trivium stream-cipher core. It loads an 80-bit key and an 80-bit IV, then runs the 1152-round warm-up. After that it XORs W bits of input per accepted beat with keystream. It sits between the input FIFO and the output FIFO of the encryption datapath. It replaces the fixed 8-bit serial-key engine with a W-bit-parallel core that has IV loading, valid/ready flow control and a keystream-usage limit.

## Interface
- W, default 8: keystream bits per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (each divides 1152 and is ≤ 64).
- MAX_WORDS, default 2**20: data beats allowed per key/IV before rekey is forced; ≥ 1.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- key_i  in  80  key; key_i[i] = K(i+1).
- iv_i  in  80  IV; iv_i[i] = IV(i+1).
- load_i  in  1  single-cycle pulse; captures key_i and iv_i and restarts the core.
- data_i  in  W  plaintext/ciphertext beat; bit 0 pairs with the earliest keystream bit.
- data_valid_i  in  1  input beat valid.
- data_ready_o  out  1  core accepts a beat this cycle.
- out_o  out  W  data_i XOR keystream.
- out_valid_o  out  1  out_o valid.
- out_ready_i  in  1  downstream accepts out_o.
- ready_o  out  1  high in RUN.
- exhausted_o  out  1  high in EXHAUSTED.
- err_o  out  1  sticky; set when data_valid_i is high while the FSM is not in RUN; cleared by load_i.

## Operation
- State s[1..288] is held as a 288-bit register.
- FSM states: IDLE, LOAD, INIT, RUN, EXHAUSTED.
- IDLE: all flags low. load_i → LOAD.
- LOAD (1 cycle):
  - s[1..80] = key, s[81..93] = 0.
  - s[94..173] = IV, s[174..177] = 0.
  - s[178..285] = 0, s[286..288] = 1.
  - Clear round counter, word counter, err_o, out_valid_o. → INIT.
- INIT: apply W rounds per cycle, output discarded. After 1152/W cycles → RUN.
- Round definition (per bit, standard Trivium):
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288, z = t1^t2^t3.
  - t1 ^= s91&s92 ^ s171; t2 ^= s175&s176 ^ s264; t3 ^= s286&s287 ^ s69.
  - Shift: s[1..93] ← (t3, s1..s92); s[94..177] ← (t1, s94..s176); s[178..288] ← (t2, s178..s287).
- W rounds per cycle are computed combinationally. This is exact for W ≤ 64 because no tap within a 64-round window depends on a bit produced in the same window.
- RUN:
  - data_ready_o = !out_valid_o || out_ready_i.
  - On beat accept (data_valid_i && data_ready_o): out_o ← data_i ^ z[W], out_valid_o ← 1, advance state by W rounds, word counter +1.
  - State advances only on accept; no keystream is skipped or reused.
  - When the word counter reaches MAX_WORDS after an accept → EXHAUSTED.
- EXHAUSTED: data_ready_o = 0. A pending out_o is still drained normally. Only load_i leaves this state.
- load_i in any state (including INIT, RUN, or simultaneously with an accept) takes priority: the accept is ignored, pending output is dropped (out_valid_o ← 0), → LOAD.
- Word counter width: $clog2(MAX_WORDS+1); it never wraps.

## Timing
- Reset values: data_ready_o, out_valid_o, ready_o, exhausted_o, err_o = 0; out_o = 0; FSM = IDLE; state register = 0.
- load_i high at cycle 0 → LOAD at cycle 1 → INIT at cycles 2 .. 1+1152/W → ready_o high from cycle 2+1152/W. For W=8: ready_o at cycle 146.
- Beat accepted at edge n → out_o/out_valid_o visible after edge n; throughput is 1 beat per cycle with continuous out_ready_i.
- out_valid_o && !out_ready_i holds out_o stable and drops data_ready_o.
- rst mid-operation: immediate return to reset values; key and IV must be reloaded.

## Structure
- Package trivium_pkg holds:
  - the FSM state enum;
  - STATE_LEN = 288 and INIT_ROUNDS = 1152;
  - tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69).
- Sub-module trivium_rounds #(W): purely combinational. Takes the 288-bit state, returns the next state and z[W-1:0]. Used for both INIT and RUN.

## Test plan
- Key = 0, IV = 0, W = 8: load, then stream 64 beats of data_i = 0x00 → out_o equals the golden-model keystream bytes; ready_o rises exactly 145 cycles after load_i.
- Same key/IV with W = 1, 8 and 64: concatenated outputs over 512 bits are identical across widths; init lengths are 1152, 144 and 18 cycles.
- Random out_ready_i stalls (50%) with continuous data_valid_i → no beat lost or duplicated; out_o is stable while stalled; the output sequence is unchanged from the no-stall run.
- MAX_WORDS = 4 → the 4th accept is followed by exhausted_o = 1 and data_ready_o = 0; a 5th data_valid_i sets err_o; load_i clears both flags.
- load_i asserted mid-INIT and in the same cycle as a RUN accept → accept ignored, out_valid_o = 0 next cycle, full 1152/W init repeated, keystream restarts from its first bit.
- rst low during RUN → all outputs at reset values on the same edge; data_valid_i high in IDLE → err_o = 1.
